// File: rtl/toggle_cover_collector_if.sv
// Hit, clear and drain signals between toggle reporters, the fuzzer feedback and the collector.
interface toggle_cover_collector_if #(
    parameter int unsigned IDX_W = 14
);
    logic             hit_valid;
    logic             hit_ready;
    logic [IDX_W-1:0] hit_index;
    logic             clear_req;
    logic             clear_busy;
    logic             new_valid;
    logic             new_ready;
    logic [IDX_W-1:0] new_index;
    logic [IDX_W:0]   covered_count;
    logic             out_of_range;

    // Hit source / drain consumer side
    modport master (
        output hit_valid, hit_index, clear_req, new_ready,
        input  hit_ready, clear_busy, new_valid, new_index, covered_count, out_of_range
    );

    // Collector side
    modport slave (
        input  hit_valid, hit_index, clear_req, new_ready,
        output hit_ready, clear_busy, new_valid, new_index, covered_count, out_of_range
    );
endinterface

// File: rtl/toggle_cover_collector.sv
// Toggle-coverage collector: covered bitmap, unique-hit count and first-hit drain FIFO.
module toggle_cover_collector #(
    parameter int unsigned COVER_TOTAL = 8940,
    parameter int unsigned IDX_W       = 14,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic clock,
    input  logic reset,
    toggle_cover_collector_if.slave cov
);
    localparam int unsigned NWORDS  = (COVER_TOTAL + WORD_W - 1) / WORD_W;
    localparam int unsigned WADDR_W = $clog2(NWORDS);
    localparam int unsigned BIT_W   = $clog2(WORD_W);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WADDR_W-1:0] sweep_ptr_q, sweep_ptr_d;
    logic [IDX_W:0]     count_q, count_d;
    logic               oor_q, oor_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [IDX_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]  bitmap_q [NWORDS];

    logic               clear_busy_c;
    logic               hit_ready_c;
    logic               fifo_full;
    logic               run_clear;
    logic               hit_fire;
    logic               in_range;
    logic               new_hit;
    logic               oor_hit;
    logic               push;
    logic               pop;
    logic [WADDR_W-1:0] word_sel;
    logic [BIT_W-1:0]   bit_sel;
    logic [WORD_W-1:0]  word_rd;

    // Hit decode: word/bit selection and first-hit detection against the bitmap
    always_comb begin
        fifo_full = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
        run_clear = (state_q == ST_RUN) && cov.clear_req;
        hit_fire  = cov.hit_valid && hit_ready_c;
        in_range  = (32'(cov.hit_index) < COVER_TOTAL);
        word_sel  = WADDR_W'(cov.hit_index >> BIT_W);
        bit_sel   = cov.hit_index[BIT_W-1:0];
        word_rd   = bitmap_q[word_sel];
        new_hit   = hit_fire && in_range && !word_rd[bit_sel];
        oor_hit   = hit_fire && !in_range;
        push      = new_hit;
        pop       = (fifo_cnt_q != '0) && cov.new_ready;
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_SWEEP;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: sweep runs exactly NWORDS cycles; clear only honoured in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SWEEP: if (sweep_ptr_q == WADDR_W'(NWORDS - 1)) state_d = ST_RUN;
            ST_RUN:   if (cov.clear_req) state_d = ST_SWEEP;
            default:  state_d = ST_SWEEP;
        endcase
    end

    // FSM outputs: busy during sweep, accept only in RUN with FIFO space and no clear
    always_comb begin
        clear_busy_c = 1'b0;
        hit_ready_c  = 1'b0;
        case (state_q)
            ST_SWEEP: clear_busy_c = 1'b1;
            ST_RUN:   hit_ready_c  = !cov.clear_req && !fifo_full;
            default:  clear_busy_c = 1'b1;
        endcase
    end

    // Next values of sweep pointer, count, sticky flag and FIFO pointers
    always_comb begin
        sweep_ptr_d = sweep_ptr_q;
        count_d     = count_q;
        oor_d       = oor_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (state_q == ST_SWEEP) begin
            if (sweep_ptr_q == WADDR_W'(NWORDS - 1)) begin
                sweep_ptr_d = '0;
            end else begin
                sweep_ptr_d = sweep_ptr_q + WADDR_W'(1);
            end
        end
        if (run_clear) begin
            sweep_ptr_d = '0;
            count_d     = '0;
            oor_d       = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fifo_cnt_d  = '0;
        end else begin
            if (new_hit) count_d = count_q + (IDX_W + 1)'(1);
            if (oor_hit) oor_d = 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            end
        end
    end

    // Control/datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sweep_ptr_q <= '0;
            count_q     <= '0;
            oor_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            sweep_ptr_q <= sweep_ptr_d;
            count_q     <= count_d;
            oor_q       <= oor_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Drain FIFO storage; reset so new_index never shows X
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem_q[i] <= '0;
        end else if (push) begin
            fifo_mem_q[wr_ptr_q] <= cov.hit_index;
        end
    end

    // Bitmap: sweep clears one word per cycle, RUN sets the hit bit in one RMW cycle
    always_ff @(posedge clock) begin
        if (state_q == ST_SWEEP) begin
            bitmap_q[sweep_ptr_q] <= '0;
        end else if (new_hit) begin
            bitmap_q[word_sel] <= word_rd | (WORD_W'(1) << bit_sel);
        end
    end

    assign cov.hit_ready     = hit_ready_c;
    assign cov.clear_busy    = clear_busy_c;
    assign cov.new_valid     = (fifo_cnt_q != '0);
    assign cov.new_index     = fifo_mem_q[rd_ptr_q];
    assign cov.covered_count = count_q;
    assign cov.out_of_range  = oor_q;
endmodule

// File: tb/tb_toggle_cover_collector.sv
// Bench for toggle_cover_collector: directed scenarios plus a random run against a bitmap/queue model.
module tb_toggle_cover_collector;
    localparam int COVER_TOTAL = 8940;
    localparam int IDX_W       = 14;
    localparam int FIFO_DEPTH  = 8;
    localparam int NWORDS      = 280;

    logic clock;
    logic reset;

    toggle_cover_collector_if #(.IDX_W(IDX_W)) ifc();

    toggle_cover_collector #(
        .COVER_TOTAL(COVER_TOTAL), .IDX_W(IDX_W), .WORD_W(32), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .cov   (ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    bit               bm_m [COVER_TOTAL];
    int               cnt_m;
    bit               oor_m;
    int               sweep_m;
    logic [IDX_W-1:0] q_m [$];

    function automatic bit exp_ready();
        return (sweep_m == 0) && !ifc.clear_req && (q_m.size() < FIFO_DEPTH);
    endfunction

    task automatic model_reset();
        foreach (bm_m[i]) bm_m[i] = 1'b0;
        cnt_m   = 0;
        oor_m   = 1'b0;
        q_m.delete();
        sweep_m = NWORDS;
    endtask

    task automatic drive(input bit v, input int idx, input bit nr, input bit clr);
        ifc.hit_valid = v;
        ifc.hit_index = IDX_W'(idx);
        ifc.new_ready = nr;
        ifc.clear_req = clr;
        #1;
    endtask

    // Apply one clock edge to the model, then move the DUT to the next falling edge
    task automatic advance();
        bit rdy;
        bit pop;
        int idx;
        rdy = exp_ready();
        pop = (q_m.size() != 0) && ifc.new_ready;
        if (sweep_m > 0) begin
            sweep_m--;
        end else if (ifc.clear_req) begin
            foreach (bm_m[i]) bm_m[i] = 1'b0;
            cnt_m = 0;
            oor_m = 1'b0;
            q_m.delete();
            sweep_m = NWORDS;
        end else begin
            if (pop) void'(q_m.pop_front());
            if (ifc.hit_valid && rdy) begin
                idx = int'(ifc.hit_index);
                if (idx >= COVER_TOTAL) begin
                    oor_m = 1'b1;
                end else if (!bm_m[idx]) begin
                    bm_m[idx] = 1'b1;
                    cnt_m++;
                    q_m.push_back(ifc.hit_index);
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    // Idle until clear_busy drops (bounded); mid_clr pulses clear_req on that sweep cycle
    task automatic run_sweep(input int mid_clr, output int n);
        n = 0;
        drive(0, 0, 1, 0);
        while (ifc.clear_busy === 1'b1 && n < 400) begin
            drive(0, 0, 1, (n == mid_clr) ? 1'b1 : 1'b0);
            advance();
            n++;
        end
        drive(0, 0, 1, 0);
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        total++; if (ifc.clear_busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", ifc.clear_busy); end
        total++; if (ifc.hit_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ifc.hit_ready); end
        total++; if (ifc.covered_count !== '0) begin bad++; $display("FAIL rst_count got=%0d exp=0", ifc.covered_count); end
        total++; if (ifc.new_valid !== 1'b0) begin bad++; $display("FAIL rst_nvalid got=%b exp=0", ifc.new_valid); end
        total++; if (ifc.out_of_range !== 1'b0) begin bad++; $display("FAIL rst_oor got=%b exp=0", ifc.out_of_range); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_sweep(-1, n);
        total++; if (n != NWORDS) begin bad++; $display("FAIL rst_sweep_len got=%0d exp=%0d", n, NWORDS); end
        total++; if (ifc.hit_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_run got=%b exp=1", ifc.hit_ready); end
        total++; if (ifc.covered_count !== '0) begin bad++; $display("FAIL rst_count_run got=%0d exp=0", ifc.covered_count); end
        total++; if (ifc.new_valid !== 1'b0) begin bad++; $display("FAIL rst_nvalid_run got=%b exp=0", ifc.new_valid); end
    endtask

    task automatic test_repeat_hit();
        drive(1, 5, 1, 0);
        total++; if (ifc.hit_ready !== exp_ready()) begin bad++; $display("FAIL rep_ready1 got=%b exp=%b", ifc.hit_ready, exp_ready()); end
        advance();
        drive(1, 5, 1, 0);
        total++; if (ifc.hit_ready !== 1'b1) begin bad++; $display("FAIL rep_ready2 got=%b exp=1", ifc.hit_ready); end
        total++; if (ifc.new_valid !== 1'b1 || ifc.new_index !== 14'd5) begin bad++; $display("FAIL rep_entry got=%b/%0d exp=1/5", ifc.new_valid, ifc.new_index); end
        total++; if (ifc.covered_count !== 15'd1) begin bad++; $display("FAIL rep_count got=%0d exp=1", ifc.covered_count); end
        advance();
        drive(0, 0, 1, 0);
        total++; if (ifc.new_valid !== 1'b0) begin bad++; $display("FAIL rep_no_second got=%b exp=0", ifc.new_valid); end
        total++; if (ifc.covered_count !== 15'd1) begin bad++; $display("FAIL rep_count2 got=%0d exp=1", ifc.covered_count); end
    endtask

    task automatic test_boundary();
        int bidx [4] = '{0, 31, 32, 8939};
        for (int i = 0; i < 4; i++) begin
            drive(1, bidx[i], 0, 0);
            total++; if (ifc.hit_ready !== 1'b1) begin bad++; $display("FAIL bnd_ready%0d got=%b exp=1", i, ifc.hit_ready); end
            advance();
        end
        drive(1, 8940, 0, 0);
        total++; if (ifc.hit_ready !== 1'b1) begin bad++; $display("FAIL bnd_oor_ready got=%b exp=1", ifc.hit_ready); end
        advance();
        drive(0, 0, 0, 0);
        total++; if (ifc.out_of_range !== 1'b1) begin bad++; $display("FAIL bnd_oor got=%b exp=1", ifc.out_of_range); end
        total++; if (int'(ifc.covered_count) != cnt_m) begin bad++; $display("FAIL bnd_count got=%0d exp=%0d", ifc.covered_count, cnt_m); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0);
            total++; if (ifc.new_valid !== 1'b1 || int'(ifc.new_index) != bidx[i]) begin bad++; $display("FAIL bnd_order%0d got=%b/%0d exp=1/%0d", i, ifc.new_valid, ifc.new_index, bidx[i]); end
            advance();
        end
        drive(0, 0, 1, 0);
        total++; if (ifc.new_valid !== 1'b0) begin bad++; $display("FAIL bnd_empty got=%b exp=0", ifc.new_valid); end
    endtask

    task automatic test_back_pressure();
        int got [$];
        int n;
        for (int i = 0; i < 8; i++) begin
            drive(1, 100 + i, 0, 0);
            total++; if (ifc.hit_ready !== 1'b1) begin bad++; $display("FAIL bp_ready%0d got=%b exp=1", i, ifc.hit_ready); end
            advance();
        end
        drive(1, 108, 0, 0);
        total++; if (ifc.hit_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", ifc.hit_ready); end
        advance();
        drive(1, 108, 1, 0);
        total++; if (ifc.hit_ready !== 1'b0) begin bad++; $display("FAIL bp_full_pop got=%b exp=0", ifc.hit_ready); end
        if (ifc.new_valid === 1'b1) got.push_back(int'(ifc.new_index));
        advance();
        drive(1, 108, 1, 0);
        total++; if (ifc.hit_ready !== 1'b1) begin bad++; $display("FAIL bp_after_full got=%b exp=1", ifc.hit_ready); end
        if (ifc.new_valid === 1'b1) got.push_back(int'(ifc.new_index));
        advance();
        drive(1, 109, 1, 0);
        total++; if (ifc.hit_ready !== exp_ready()) begin bad++; $display("FAIL bp_ready109 got=%b exp=%b", ifc.hit_ready, exp_ready()); end
        if (ifc.new_valid === 1'b1) got.push_back(int'(ifc.new_index));
        advance();
        n = 0;
        drive(0, 0, 1, 0);
        while (ifc.new_valid === 1'b1 && n < 20) begin
            got.push_back(int'(ifc.new_index));
            advance();
            drive(0, 0, 1, 0);
            n++;
        end
        total++; if (got.size() != 10) begin bad++; $display("FAIL bp_drain_len got=%0d exp=10", got.size()); end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            total++; if (got[i] != 100 + i) begin bad++; $display("FAIL bp_order%0d got=%0d exp=%0d", i, got[i], 100 + i); end
        end
    endtask

    task automatic test_clear();
        int n;
        drive(0, 0, 1, 1);
        advance();
        run_sweep(-1, n);
        for (int i = 0; i < 4; i++) begin
            drive(1, 200 + i, 0, 0);
            advance();
        end
        drive(1, 9000, 0, 0);
        advance();
        drive(0, 0, 1, 0);
        advance();
        drive(0, 0, 0, 0);
        total++; if (ifc.covered_count !== 15'd4 || q_m.size() != 3) begin bad++; $display("FAIL clr_setup got=%0d/%0d exp=4/3", ifc.covered_count, q_m.size()); end
        drive(1, 300, 0, 1);
        total++; if (ifc.hit_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%b exp=0", ifc.hit_ready); end
        advance();
        drive(0, 0, 0, 0);
        total++; if (ifc.new_valid !== 1'b0) begin bad++; $display("FAIL clr_nvalid got=%b exp=0", ifc.new_valid); end
        total++; if (ifc.covered_count !== '0) begin bad++; $display("FAIL clr_count got=%0d exp=0", ifc.covered_count); end
        total++; if (ifc.out_of_range !== 1'b0) begin bad++; $display("FAIL clr_oor got=%b exp=0", ifc.out_of_range); end
        run_sweep(100, n);
        total++; if (n != NWORDS) begin bad++; $display("FAIL clr_sweep_len got=%0d exp=%0d", n, NWORDS); end
        drive(1, 200, 1, 0);
        total++; if (ifc.hit_ready !== 1'b1) begin bad++; $display("FAIL clr_ready_run got=%b exp=1", ifc.hit_ready); end
        advance();
        drive(0, 0, 1, 0);
        total++; if (ifc.new_valid !== 1'b1 || ifc.new_index !== 14'd200) begin bad++; $display("FAIL clr_rereport got=%b/%0d exp=1/200", ifc.new_valid, ifc.new_index); end
        total++; if (ifc.covered_count !== 15'd1) begin bad++; $display("FAIL clr_recount got=%0d exp=1", ifc.covered_count); end
        advance();
    endtask

    task automatic test_async_reset();
        int n;
        drive(1, 400, 0, 0);
        advance();
        drive(1, 9999, 0, 0);
        advance();
        drive(0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        total++; if (ifc.clear_busy !== 1'b1) begin bad++; $display("FAIL ar_busy got=%b exp=1", ifc.clear_busy); end
        total++; if (ifc.hit_ready !== 1'b0) begin bad++; $display("FAIL ar_ready got=%b exp=0", ifc.hit_ready); end
        total++; if (ifc.covered_count !== '0) begin bad++; $display("FAIL ar_count got=%0d exp=0", ifc.covered_count); end
        total++; if (ifc.new_valid !== 1'b0) begin bad++; $display("FAIL ar_nvalid got=%b exp=0", ifc.new_valid); end
        total++; if (ifc.out_of_range !== 1'b0) begin bad++; $display("FAIL ar_oor got=%b exp=0", ifc.out_of_range); end
        @(negedge clock);
        reset = 1'b0;
        run_sweep(-1, n);
        total++; if (n != NWORDS) begin bad++; $display("FAIL ar_sweep_len got=%0d exp=%0d", n, NWORDS); end
    endtask

    task automatic test_random();
        int  idx;
        bit  v;
        bit  nr;
        bit  er;
        for (int c = 0; c < 400; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            nr  = ($urandom_range(0, 2) != 0);
            idx = ($urandom_range(0, 19) == 0) ? COVER_TOTAL + int'($urandom_range(0, 200))
                                               : 1000 + int'($urandom_range(0, 63));
            drive(v, idx, nr, 0);
            er = exp_ready();
            total++; if (ifc.hit_ready !== er) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, ifc.hit_ready, er); end
            total++; if (ifc.new_valid !== (q_m.size() != 0)) begin bad++; $display("FAIL rnd_nvalid c=%0d got=%b exp=%b", c, ifc.new_valid, q_m.size() != 0); end
            if (q_m.size() != 0) begin
                total++; if (ifc.new_index !== q_m[0]) begin bad++; $display("FAIL rnd_nidx c=%0d got=%0d exp=%0d", c, ifc.new_index, q_m[0]); end
            end
            advance();
            total++; if (int'(ifc.covered_count) != cnt_m) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, ifc.covered_count, cnt_m); end
            total++; if (ifc.out_of_range !== oor_m) begin bad++; $display("FAIL rnd_oor c=%0d got=%b exp=%b", c, ifc.out_of_range, oor_m); end
        end
    endtask

    initial begin
        test_reset();
        test_repeat_hit();
        test_boundary();
        test_back_pressure();
        test_clear();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/toggle_cover_collector.md
Name: toggle_cover_collector

Overview:
- Receiving end of the toggle-coverage hit stream.
- Accepts cover-point hit events (absolute cover index, COVER_INDEX + bit) from toggle reporter instances through a valid/ready port.
- Keeps a per-point "already covered" bitmap and a running unique-hit count.
- Emits each first-time-covered index once on a drain stream, for the fuzzer-side coverage feedback.

Parameters:
- COVER_TOTAL, 8940, number of cover points; legal indices are 0..COVER_TOTAL-1.
- IDX_W, 14, width of index buses; must satisfy 2^IDX_W >= COVER_TOTAL.
- WORD_W, 32, bitmap word width; NWORDS = ceil(COVER_TOTAL/WORD_W) = 280.
- FIFO_DEPTH, 8, depth of the new-hit drain FIFO; power of two, >= 2.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- hit_valid  in  1  hit event present.
- hit_ready  out  1  collector accepts the hit this cycle.
- hit_index  in  IDX_W  absolute cover index of the hit.
- clear_req  in  1  single-cycle pulse: wipe bitmap, count and FIFO.
- clear_busy  out  1  high while the bitmap sweep is in progress.
- new_valid  out  1  drain FIFO non-empty.
- new_ready  in  1  drain consumer accepts the head entry.
- new_index  out  IDX_W  index of a first-time-covered point.
- covered_count  out  IDX_W+1  number of distinct points covered since the last sweep.
- out_of_range  out  1  sticky flag: a hit with index >= COVER_TOTAL was accepted.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state = SWEEP, sweep pointer = 0;
  - covered_count = 0, out_of_range = 0;
  - FIFO empty, new_valid = 0;
  - clear_busy = 1, hit_ready = 0.
- Bitmap words are not reset; the sweep clears them.
- State machine:
  - SWEEP: clears one bitmap word per cycle, word = pointer. After word NWORDS-1 is cleared the next state is RUN. Sweep duration is exactly NWORDS cycles.
  - RUN: normal operation.
  - clear_req in RUN: next state SWEEP, pointer = 0, covered_count = 0, out_of_range = 0, FIFO flushed. new_valid drops the next cycle.
  - clear_req in SWEEP: ignored. The sweep is not restarted.
- clear_busy = (state == SWEEP).
- hit_ready = (state == RUN) && !clear_req && !fifo_full. It is combinational and independent of hit_valid.
- A hit is accepted when hit_valid && hit_ready. Single-cycle read-modify-write on word hit_index/WORD_W, bit hit_index%WORD_W, so back-to-back hits to the same word are exact with no pipeline hazard.
- Accepted hit, in range, bit clear: set the bit, covered_count += 1, push hit_index into the FIFO. All visible the next cycle.
- Accepted hit, in range, bit already set: no state change.
- Accepted hit with hit_index >= COVER_TOTAL: no bitmap/count/FIFO change; out_of_range set to 1, sticky until reset or clear.
- FIFO behaviour:
  - new_valid = !empty; new_index = head entry.
  - Pop on new_valid && new_ready.
  - Head is stable while new_valid && !new_ready.
  - When full, hit_ready = 0 even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full: occupancy unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Entries leave in acceptance order.
- covered_count never exceeds COVER_TOTAL; no wrap logic is required.
- Reset asserted mid-sweep or mid-run: immediate return to the reset state above.
- Outputs carry no X after reset; bitmap contents are don't-care until the sweep completes.

Test Plan:
- Reset release:
  - clear_busy = 1 and hit_ready = 0 for exactly 280 cycles.
  - Then clear_busy = 0, hit_ready = 1, covered_count = 0, new_valid = 0.
- Hit index 5, then index 5 again, with new_ready = 1:
  - One drain entry new_index = 5; covered_count = 1.
  - Second hit accepted but produces no entry.
- Boundary hits 0, 31, 32, 8939 (word 279, bit 11) back-to-back:
  - Four entries, in order; covered_count = 4.
  - Hit 8940: accepted, out_of_range = 1, count stays 4.
- new_ready = 0, ten distinct hits offered:
  - First 8 accepted, hit_ready = 0 on the 9th.
  - Raising new_ready drains entries 1..8 in order.
  - The 9th is accepted the cycle after the FIFO leaves full.
- clear_req pulse with count = 4, FIFO holding 3 entries, hit_valid high the same cycle:
  - Hit not accepted; new_valid = 0 next cycle; count = 0; out_of_range = 0; 280-cycle sweep.
  - A second clear_req mid-sweep does not extend it.
  - A previously covered index is then reported again.
- Reset asserted asynchronously mid-run between clock edges:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - A full 280-cycle sweep follows release.
